tx_tlp_arbiter: RTL and testbench

//   Shares the PCIe endpoint Tx Local-Link (trn_td/trn_tsof_n/...) between three TLP

---
 rtl/tx_tlp_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tx_tlp_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_tlp_arbiter.sv
// Round-robin arbiter sharing the endpoint Tx Local-Link between the completer, posted and non-posted TLP sources.
// Latency: grant registered one cycle after an eligible request; granted data is muxed through combinationally.
// Backpressure: trn_tdst_rdy_n is fanned back to the granted source only; a stall freezes arbiter state and the timeout counter.
module tx_tlp_arbiter #(
    parameter int GNT_TIMEOUT = 16,   // idle cycles allowed before the first SOF beat
    parameter int CNT_W       = 5     // 2**CNT_W must exceed GNT_TIMEOUT
) (
    input  logic           trn_clk,
    input  logic           trn_reset_n,
    input  logic           trn_lnk_up_n,
    input  logic [3:0]     trn_tbuf_av,
    input  logic           trn_tdst_rdy_n,
    output logic [63:0]    trn_td,
    output logic [7:0]     trn_trem_n,
    output logic           trn_tsof_n,
    output logic           trn_teof_n,
    output logic           trn_tsrc_rdy_n,
    output logic           trn_tsrc_dsc_n,
    input  logic [2:0]     req,
    output logic [2:0]     gnt,
    input  logic [191:0]   req_td,
    input  logic [23:0]    req_trem_n,
    input  logic [2:0]     req_tsof_n,
    input  logic [2:0]     req_teof_n,
    input  logic [2:0]     req_tsrc_rdy_n,
    output logic [2:0]     req_tdst_rdy_n
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One Local-Link beat as seen on either side of the mux.
    typedef struct packed {
        logic [63:0] td;
        logic [7:0]  trem_n;
        logic        tsof_n;
        logic        teof_n;
        logic        tsrc_rdy_n;
    } beat_t;

    localparam beat_t BEAT_IDLE = '{
        td:         64'h0,
        trem_n:     8'hFF,
        tsof_n:     1'b1,
        teof_n:     1'b1,
        tsrc_rdy_n: 1'b1
    };

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(GNT_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        gnt_nxt;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_ptr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              in_pkt;
    logic              in_pkt_nxt;
    logic              dsc_n_nxt;

    logic [2:0]        elig;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic [1:0]        winner;
    beat_t             src_beat [3];
    beat_t             mux_beat;
    logic              beat_acc;

    // Bit 3 of tbuf_av is a class this block never issues.
    logic              unused_tbuf_av;
    assign unused_tbuf_av = trn_tbuf_av[3];

    // Next index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // A source may only win when the endpoint has buffer space in its class and the link is up.
    // Note the requester and tbuf_av bit orders are reversed relative to each other.
    always_comb begin
        elig = 3'b000;
        if (!trn_lnk_up_n) begin
            elig = {req[2] & trn_tbuf_av[0],
                    req[1] & trn_tbuf_av[1],
                    req[0] & trn_tbuf_av[2]};
        end
    end

    assign cand1 = rr_next(rr_ptr);
    assign cand2 = rr_next(cand1);

    // Round-robin pick: first eligible index after the last winner, the last winner itself checked last.
    always_comb begin
        winner = rr_ptr;
        if (elig[cand1]) begin
            winner = cand1;
        end else if (elig[cand2]) begin
            winner = cand2;
        end
    end

    // Unpack the flat requester buses into per-source beats.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_beat[i].td         = req_td[64*i +: 64];
            src_beat[i].trem_n     = req_trem_n[8*i +: 8];
            src_beat[i].tsof_n     = req_tsof_n[i];
            src_beat[i].teof_n     = req_teof_n[i];
            src_beat[i].tsrc_rdy_n = req_tsrc_rdy_n[i];
        end
    end

    // Zero-latency data mux keyed directly off the registered one-hot grant.
    always_comb begin
        mux_beat = BEAT_IDLE;
        case (gnt)
            3'b001:  mux_beat = src_beat[0];
            3'b010:  mux_beat = src_beat[1];
            3'b100:  mux_beat = src_beat[2];
            default: mux_beat = BEAT_IDLE;
        endcase
    end

    assign trn_td         = mux_beat.td;
    assign trn_trem_n     = mux_beat.trem_n;
    assign trn_tsof_n     = mux_beat.tsof_n;
    assign trn_teof_n     = mux_beat.teof_n;
    assign trn_tsrc_rdy_n = mux_beat.tsrc_rdy_n;

    // Only the granted source ever sees the endpoint ready.
    assign req_tdst_rdy_n = ~gnt | {3{trn_tdst_rdy_n}};

    assign beat_acc = (state == ST_GRANT) && !mux_beat.tsrc_rdy_n && !trn_tdst_rdy_n;

    // Arbitration FSM: issue a grant, follow the TLP to EOF, revoke on idle timeout or link loss.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        in_pkt_nxt = in_pkt;
        dsc_n_nxt  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (|elig) begin
                    state_nxt  = ST_GRANT;
                    gnt_nxt    = 3'b001 << winner;
                    rr_ptr_nxt = winner;
                    cnt_nxt    = '0;
                end
            end
            ST_GRANT: begin
                if (trn_lnk_up_n) begin
                    // Link loss wins over everything; a frame already started must be discarded downstream.
                    state_nxt  = ST_IDLE;
                    gnt_nxt    = 3'b000;
                    in_pkt_nxt = 1'b0;
                    dsc_n_nxt  = ~in_pkt;
                end else if (beat_acc && !mux_beat.teof_n) begin
                    // EOF (possibly on the SOF beat) ends the grant; IDLE gives the bubble cycle.
                    state_nxt  = ST_IDLE;
                    gnt_nxt    = 3'b000;
                    in_pkt_nxt = 1'b0;
                end else if (beat_acc && !mux_beat.tsof_n) begin
                    in_pkt_nxt = 1'b1;
                end else if (!in_pkt && !trn_tdst_rdy_n) begin
                    // Granted source has not started its frame; rr_ptr stays put so the others go first.
                    if (cnt == TIMEOUT_LAST) begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = 3'b000;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = 3'b000;
            end
        endcase
    end

    // State register; async reset leaves rr_ptr on 2 so requester 0 wins the first search.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state          <= ST_IDLE;
            gnt            <= 3'b000;
            rr_ptr         <= 2'd2;
            cnt            <= '0;
            in_pkt         <= 1'b0;
            trn_tsrc_dsc_n <= 1'b1;
        end else begin
            state          <= state_nxt;
            gnt            <= gnt_nxt;
            rr_ptr         <= rr_ptr_nxt;
            cnt            <= cnt_nxt;
            in_pkt         <= in_pkt_nxt;
            trn_tsrc_dsc_n <= dsc_n_nxt;
        end
    end

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Bench for tx_tlp_arbiter: three modelled TLP sources, expected beats and grant order queued at load time.
// Latency: grant order checked on each grant rising edge, beats checked as they are accepted.
// Backpressure: optional random trn_tdst_rdy_n stalls driven by the bench.
module tb_tx_tlp_arbiter;

    logic           trn_clk = 1'b0;
    logic           trn_reset_n;
    logic           trn_lnk_up_n;
    logic [3:0]     trn_tbuf_av;
    logic           trn_tdst_rdy_n;
    logic [63:0]    trn_td;
    logic [7:0]     trn_trem_n;
    logic           trn_tsof_n;
    logic           trn_teof_n;
    logic           trn_tsrc_rdy_n;
    logic           trn_tsrc_dsc_n;
    logic [2:0]     req;
    logic [2:0]     gnt;
    logic [191:0]   req_td;
    logic [23:0]    req_trem_n;
    logic [2:0]     req_tsof_n;
    logic [2:0]     req_teof_n;
    logic [2:0]     req_tsrc_rdy_n;
    logic [2:0]     req_tdst_rdy_n;

    always #5 trn_clk = ~trn_clk;

    tx_tlp_arbiter dut (
        .trn_clk        (trn_clk),
        .trn_reset_n    (trn_reset_n),
        .trn_lnk_up_n   (trn_lnk_up_n),
        .trn_tbuf_av    (trn_tbuf_av),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
        .req            (req),
        .gnt            (gnt),
        .req_td         (req_td),
        .req_trem_n     (req_trem_n),
        .req_tsof_n     (req_tsof_n),
        .req_teof_n     (req_teof_n),
        .req_tsrc_rdy_n (req_tsrc_rdy_n),
        .req_tdst_rdy_n (req_tdst_rdy_n)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nacc  = 0;
    int last_eof = 0;
    bit mon_en  = 1'b0;
    bit gap_chk = 1'b0;
    bit stall_en = 1'b0;

    // Source model state: packets left, length, current beat, packet id, never-ready flag.
    int spk [3];
    int slen [3];
    int sb [3];
    int sid [3];
    bit squiet [3];
    bit acc [3];

    logic [73:0] q0 [$];
    logic [73:0] q1 [$];
    logic [73:0] q2 [$];
    int          gq [$];
    int          cur_src = 0;
    logic [2:0]  gnt_prev = 3'b000;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat encoding {td, trem_n, tsof_n, teof_n}; td tags source, packet and beat.
    function automatic logic [73:0] mk_beat(input int s, input int id, input int b, input int len);
        logic [63:0] td;
        td = {8'hC0, 8'(s), 16'(id), 32'(b) ^ 32'h5A5A_0000};
        return {td, (b == len - 1) ? 8'h0F : 8'h00, (b != 0), (b != len - 1)};
    endfunction

    task automatic push_exp(input int s, input logic [73:0] bt);
        case (s)
            0:       q0.push_back(bt);
            1:       q1.push_back(bt);
            default: q2.push_back(bt);
        endcase
    endtask

    task automatic pop_exp(input int s, output logic [73:0] bt, output bit ok);
        ok = 1'b0;
        bt = '0;
        case (s)
            0:       if (q0.size() > 0) begin bt = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin bt = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin bt = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic load(input int s, input int n, input int len, input bit quiet);
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < len; b++) begin
                if (!quiet) push_exp(s, mk_beat(s, sid[s] + p, b, len));
            end
        end
        spk[s]    = n;
        slen[s]   = len;
        sb[s]     = 0;
        squiet[s] = quiet;
    endtask

    task automatic flush(input int s);
        spk[s]    = 0;
        sb[s]     = 0;
        squiet[s] = 1'b0;
        case (s)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic smp();
        @(negedge trn_clk);
        #1;
    endtask

    task automatic step();
        @(posedge trn_clk);
        #2;
    endtask

    task automatic wait_gnt(input logic [2:0] e, input int lim, input string tag);
        int n = 0;
        do begin
            smp();
            n++;
        end while (gnt !== e && n < lim);
        check(tag, gnt, e);
    endtask

    task automatic wait_acc(input int target, input int lim, input string tag);
        int n = 0;
        do begin
            smp();
            n++;
        end while (nacc < target && n < lim);
        check(tag, (nacc >= target), 1);
    endtask

    task automatic wait_drain(input int lim, input string tag);
        int n = 0;
        do begin
            smp();
            n++;
        end while ((q0.size() + q1.size() + q2.size() + gq.size()) != 0 && n < lim);
        check(tag, q0.size() + q1.size() + q2.size() + gq.size(), 0);
    endtask

    // Source models and output monitor: sample at negedge, advance sources just after posedge.
    initial begin : src_mon
        logic [73:0] got;
        logic [73:0] e;
        logic [73:0] bt;
        bit          ok;
        forever begin
            @(negedge trn_clk);
            cyc++;
            if (mon_en) begin
                if (gnt != 3'b000 && gnt_prev == 3'b000) begin
                    check("gnt_onehot", $onehot(gnt), 1);
                    if (gq.size() == 0) begin
                        check("gnt_extra", gnt, 3'b000);
                    end else begin
                        cur_src = gq.pop_front();
                        check("gnt_order", gnt, 3'b001 << cur_src);
                    end
                end
                if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                    got = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
                    pop_exp(cur_src, e, ok);
                    if (!ok) check("beat_extra", got, '0);
                    else     check("beat", got, e);
                    nacc++;
                    if (!trn_tsof_n && gap_chk && last_eof > 0) check("bubble", cyc - last_eof, 2);
                    if (!trn_teof_n) last_eof = cyc;
                end
            end
            gnt_prev = gnt;
            for (int i = 0; i < 3; i++) acc[i] = !req_tsrc_rdy_n[i] && !req_tdst_rdy_n[i];
            @(posedge trn_clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i] && trn_reset_n && spk[i] != 0) begin
                    if (sb[i] == slen[i] - 1) begin
                        sb[i] = 0;
                        spk[i]--;
                        sid[i]++;
                    end else begin
                        sb[i]++;
                    end
                end
                bt = mk_beat(i, sid[i], sb[i], (slen[i] == 0) ? 1 : slen[i]);
                req_td[64*i +: 64]    = bt[73:10];
                req_trem_n[8*i +: 8]  = bt[9:2];
                req_tsof_n[i]         = bt[1];
                req_teof_n[i]         = bt[0];
                req[i]                = (spk[i] != 0);
                req_tsrc_rdy_n[i]     = !(spk[i] != 0 && !squiet[i]);
            end
            trn_tdst_rdy_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int base;
        int hold;
        int dsc_cnt;
        int gnt_cnt;
        trn_reset_n    = 1'b0;
        trn_lnk_up_n   = 1'b1;
        trn_tbuf_av    = 4'hF;
        trn_tdst_rdy_n = 1'b0;
        req            = 3'b000;
        req_td         = '0;
        req_trem_n     = '1;
        req_tsof_n     = '1;
        req_teof_n     = '1;
        req_tsrc_rdy_n = '1;
        for (int i = 0; i < 3; i++) begin
            spk[i] = 0; slen[i] = 0; sb[i] = 0; sid[i] = 0; squiet[i] = 1'b0; acc[i] = 1'b0;
        end

        // Reset values
        repeat (3) smp();
        check("rst_gnt", gnt, 3'b000);
        check("rst_src_rdy", trn_tsrc_rdy_n, 1'b1);
        check("rst_td", trn_td, 64'h0);
        check("rst_trem", trn_trem_n, 8'hFF);
        check("rst_sof_eof", {trn_tsof_n, trn_teof_n}, 2'b11);
        check("rst_dsc", trn_tsrc_dsc_n, 1'b1);
        check("rst_dst_rdy", req_tdst_rdy_n, 3'b111);
        step();
        trn_reset_n  = 1'b1;
        trn_lnk_up_n = 1'b0;
        mon_en       = 1'b1;
        step();

        // 1: all three request, 4-beat TLPs, round robin 0,1,2 with one bubble
        gap_chk = 1'b1;
        base = nacc;
        for (int r = 0; r < 2; r++) for (int s = 0; s < 3; s++) gq.push_back(s);
        load(0, 2, 4, 1'b0);
        load(1, 2, 4, 1'b0);
        load(2, 2, 4, 1'b0);
        wait_drain(300, "t1_drain");
        check("t1_beats", nacc - base, 24);
        gap_chk = 1'b0;

        // 2: posted blocked by tbuf_av[1]
        step();
        trn_tbuf_av = 4'b1101;
        gq.push_back(1);
        load(1, 1, 2, 1'b0);
        gnt_cnt = 0;
        repeat (20) begin
            smp();
            if (gnt != 3'b000) gnt_cnt++;
        end
        check("t2_blocked", gnt_cnt, 0);
        step();
        trn_tbuf_av = 4'hF;
        smp();
        check("t2_pre", gnt, 3'b000);
        smp();
        check("t2_gnt", gnt, 3'b010);
        wait_drain(50, "t2_drain");

        // 3: granted non-posted never starts; revoked after 16 cycles, pending req0 next
        step();
        gq.push_back(2);
        gq.push_back(0);
        load(2, 1, 4, 1'b1);
        wait_gnt(3'b100, 10, "t3_gnt2");
        hold = 1;
        step();
        load(0, 1, 4, 1'b0);
        do begin
            smp();
            if (gnt == 3'b100) hold++;
        end while (gnt == 3'b100 && hold < 40);
        check("t3_hold", hold, 16);
        check("t3_idle", gnt, 3'b000);
        wait_gnt(3'b001, 5, "t3_gnt0");
        step();
        flush(2);
        wait_drain(50, "t3_drain");

        // 4: random endpoint stalls during 6-beat TLPs
        step();
        stall_en = 1'b1;
        base = nacc;
        gq.push_back(1); gq.push_back(0); gq.push_back(1); gq.push_back(0);
        load(0, 2, 6, 1'b0);
        load(1, 2, 6, 1'b0);
        wait_drain(400, "t4_drain");
        check("t4_beats", nacc - base, 24);
        step();
        stall_en = 1'b0;
        step();

        // 5: link drops after beat 2 of 5
        base = nacc;
        gq.push_back(0);
        load(0, 1, 5, 1'b0);
        wait_acc(base + 2, 30, "t5_two_beats");
        step();
        trn_lnk_up_n = 1'b1;
        smp();
        dsc_cnt = 0;
        gnt_cnt = 0;
        repeat (12) begin
            smp();
            if (!trn_tsrc_dsc_n) dsc_cnt++;
            if (gnt != 3'b000) gnt_cnt++;
        end
        check("t5_dsc", dsc_cnt, 1);
        check("t5_no_gnt", gnt_cnt, 0);
        step();
        flush(0);
        step();
        step();
        trn_lnk_up_n = 1'b0;
        repeat (3) smp();
        check("t5_after_up", gnt, 3'b000);
        check("t5_gq", gq.size(), 0);

        // 6: async reset mid-TLP, then req0 wins first again
        step();
        base = nacc;
        gq.push_back(1);
        load(1, 1, 4, 1'b0);
        wait_acc(base + 2, 30, "t6_two_beats");
        #1;
        trn_reset_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("t6_gnt", gnt, 3'b000);
        check("t6_src_rdy", trn_tsrc_rdy_n, 1'b1);
        check("t6_td", trn_td, 64'h0);
        check("t6_trem", trn_trem_n, 8'hFF);
        check("t6_sof_eof", {trn_tsof_n, trn_teof_n}, 2'b11);
        check("t6_dsc", trn_tsrc_dsc_n, 1'b1);
        check("t6_dst_rdy", req_tdst_rdy_n, 3'b111);
        flush(1);
        gq.delete();
        step();
        step();
        trn_reset_n = 1'b1;
        mon_en = 1'b1;
        gq.push_back(0);
        gq.push_back(2);
        load(0, 1, 2, 1'b0);
        load(2, 1, 2, 1'b0);
        wait_drain(50, "t6_drain");

        repeat (3) smp();
        check("end_gnt", gnt, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
